// File: rtl/hmmm_pkg.sv
// Shared constants and types for the hmmm program-load path.
// Widths match the core's 256-word, 16-bit instruction memory.
package hmmm_pkg;
  localparam int HMMM_ADDR_W = 8;
  localparam int HMMM_DATA_W = 16;
  localparam int FRAME_LEN   = 1 + HMMM_DATA_W;

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} tx_state_e;
endpackage

// File: rtl/hmmm_prog_tx_if.sv
// Host-side word push port of the program transmitter.
interface hmmm_prog_tx_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              finish;

  modport master (output wr_valid, wr_addr, wr_data, finish, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, finish, output wr_ready);
endinterface

// File: rtl/hmmm_prog_fifo.sv
// Small synchronous FIFO; push and pop in the same cycle are both honoured.
module hmmm_prog_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/hmmm_prog_tx.sv
// Serialises queued (addr, instr) pairs onto the core's pgrm_addr/pgrm_data
// lines and holds the core in reset for the whole load session.
module hmmm_prog_tx
  import hmmm_pkg::*;
#(
  parameter int ADDR_W     = HMMM_ADDR_W,
  parameter int DATA_W     = HMMM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2
) (
  input  logic              clk,
  input  logic              rst,
  hmmm_prog_tx_if.slave     host,
  output logic              pgrm_addr,
  output logic              pgrm_data,
  output logic              core_hold,
  output logic              busy,
  output logic [ADDR_W:0]   frames_sent
);
  localparam int CNT_W = $clog2(((DATA_W > GAP) ? DATA_W : GAP) + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  tx_state_e                state, state_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic [ADDR_W-1:0]        addr_sr;
  logic [DATA_W-1:0]        data_sr;
  logic                     pop, shift, frame_done, out_a, out_d;
  logic                     push, fifo_full, fifo_empty, fin_pend;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CW-1:0]            fifo_count;

  assign push          = host.wr_valid && host.wr_ready;
  assign host.wr_ready = !fifo_full;

  hmmm_prog_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host.wr_valid),
    .wdata ({host.wr_addr, host.wr_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Line values are decided here for the cycle after the edge, so every
  // frame bit leaves a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pop        = 1'b0;
    shift      = 1'b0;
    frame_done = 1'b0;
    out_a      = 1'b0;
    out_d      = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        state_nx = START;
        pop      = 1'b1;
        out_a    = 1'b1;
      end
      START: begin
        state_nx = SHIFT;
        shift    = 1'b1;
        out_a    = addr_sr[ADDR_W-1];
        out_d    = data_sr[DATA_W-1];
        cnt_nx   = CNT_W'(1);
      end
      SHIFT: if (cnt == CNT_W'(DATA_W)) begin
        state_nx   = hmmm_pkg::GAP;
        cnt_nx     = CNT_W'(1);
        frame_done = 1'b1;
      end else begin
        shift  = 1'b1;
        out_a  = addr_sr[ADDR_W-1];
        out_d  = data_sr[DATA_W-1];
        cnt_nx = cnt + CNT_W'(1);
      end
      hmmm_pkg::GAP: if (cnt == CNT_W'(GAP)) begin
        if (!fifo_empty) begin
          state_nx = START;
          pop      = 1'b1;
          out_a    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      pgrm_addr   <= 1'b0;
      pgrm_data   <= 1'b0;
      frames_sent <= '0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pgrm_addr <= out_a;
      pgrm_data <= out_d;
      busy      <= (state != IDLE) || (fifo_count != '0);
      if (frame_done) frames_sent <= frames_sent + (ADDR_W+1)'(1);
      // Address shifts in zeros, so it reads 0 once its bits are spent.
      if (pop) begin
        addr_sr <= head[DATA_W +: ADDR_W];
        data_sr <= head[DATA_W-1:0];
      end else if (shift) begin
        addr_sr <= {addr_sr[ADDR_W-2:0], 1'b0};
        data_sr <= {data_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Release waits for IDLE so the trailing gap of the last frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_hold <= 1'b0;
      fin_pend  <= 1'b0;
    end else if (core_hold && fin_pend && fifo_empty && state == IDLE && !push) begin
      core_hold <= 1'b0;
      fin_pend  <= 1'b0;
    end else begin
      if (push) core_hold <= 1'b1;
      if (host.finish && (core_hold || push)) fin_pend <= 1'b1;
    end
  end
endmodule
